// File: rtl/adc_buf_capture_pkg.sv
// Shared types and constants for the ADC buffer capture block.
package adc_buf_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam logic [1:0] TRIG_SW     = 2'd0;
    localparam logic [1:0] TRIG_SYSREF = 2'd1;
    localparam logic [1:0] TRIG_IMM    = 2'd2;
    localparam logic [1:0] TRIG_SW_ALT = 2'd3;

    localparam int LANE_W = 16;

    function automatic logic is_sw_mode(input logic [1:0] mode);
        return (mode == TRIG_SW) || (mode == TRIG_SW_ALT);
    endfunction

endpackage

// File: rtl/adc_cap_chsel.sv
// Per-buffer channel select, optional test-pattern source and output register.
// Pattern logic exists only when ADC_BUF_CAPTURE_TEST_PATTERN_EN is defined.
module adc_cap_chsel
    import adc_buf_capture_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int ADC_WIDTH = 128,
    parameter int SEL_W     = 2
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [NCH*ADC_WIDTH-1:0] s_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     load,
    input  logic                     first,
    input  logic                     tp_en,
    output logic [ADC_WIDTH-1:0]     m_data
);

    logic [ADC_WIDTH-1:0] mux_data;
    logic [ADC_WIDTH-1:0] beat_data;

    // Out-of-range selects never match and fall back to channel 0.
    always_comb begin
        mux_data = s_data[ADC_WIDTH-1:0];
        for (int k = 0; k < NCH; k++) begin
            if (sel == SEL_W'(k))
                mux_data = s_data[k*ADC_WIDTH +: ADC_WIDTH];
        end
    end

`ifdef ADC_BUF_CAPTURE_TEST_PATTERN_EN
    localparam int LANES = ADC_WIDTH / LANE_W;

    logic [LANE_W-1:0] base_q;
    logic [LANE_W-1:0] base_cur;

    assign base_cur = first ? '0 : base_q;

    always_comb begin
        beat_data = mux_data;
        if (tp_en) begin
            for (int i = 0; i < LANES; i++)
                beat_data[i*LANE_W +: LANE_W] = base_cur + LANE_W'(i);
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst)
            base_q <= '0;
        else if (load)
            base_q <= base_cur + LANE_W'(LANES);
    end
`else
    logic unused_tp;
    assign unused_tp = tp_en ^ first;
    assign beat_data = mux_data;
`endif

    always_ff @(posedge aclk or posedge arst) begin
        if (arst)
            m_data <= '0;
        else if (load)
            m_data <= beat_data;
    end

endmodule

// File: rtl/adc_buf_capture.sv
// Triggered fixed-length capture of routed ADC streams into NBUF buffer streams.
// Optional test pattern source: define ADC_BUF_CAPTURE_TEST_PATTERN_EN.
//
// state      | meaning
// IDLE    0  | waiting for arm with non-zero length
// ARMED   1  | configuration latched, waiting for trigger
// CAPTURE 2  | one beat per cycle, down-counter holds beats remaining
// DONE    3  | capture complete, done held until next arm or abort
module adc_buf_capture
    import adc_buf_capture_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int NBUF      = 4,
    parameter int ADC_WIDTH = 128,
    parameter int LEN_W     = 16
) (
    input  logic                              aclk,
    input  logic                              arst,
    input  logic [NCH*ADC_WIDTH-1:0]          s_axis_tdata,
    input  logic [NCH-1:0]                    s_axis_tvalid,
    output logic [NCH-1:0]                    s_axis_tready,
    output logic [NBUF*ADC_WIDTH-1:0]         m_axis_tdata,
    output logic [NBUF-1:0]                   m_axis_tvalid,
    input  logic [NBUF-1:0]                   m_axis_tready,
    input  logic [NBUF*$clog2(NCH)-1:0]       src_sel,
    input  logic [1:0]                        trig_mode,
    input  logic [LEN_W-1:0]                  cap_len,
    input  logic                              arm,
    input  logic                              sw_trig,
    input  logic                              abort,
    input  logic                              sysref,
    input  logic                              test_pattern_en,
    output logic [1:0]                        state,
    output logic                              done,
    output logic [NBUF-1:0]                   overflow
);

    localparam int SEL_W = $clog2(NCH);

    cap_state_e              state_q;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        cnt_q;
    logic [NBUF*SEL_W-1:0]   sel_q;
    logic [1:0]              mode_q;
    logic                    tvalid_q;
    logic                    done_q;
    logic [NBUF-1:0]         ovf_q;
    logic                    sysref_q;
    logic                    sysref_d;
    logic                    tp_q;

    logic sysref_rise;
    logic trig_hit;
    logic arm_ok;
    logic beat_load;
    logic unused_in;

    assign unused_in = ^s_axis_tvalid;

    assign sysref_rise = sysref_q & ~sysref_d;

    always_comb begin
        trig_hit = 1'b0;
        if (state_q == ST_ARMED) begin
            if (is_sw_mode(mode_q))
                trig_hit = sw_trig;
            else if (mode_q == TRIG_SYSREF)
                trig_hit = sysref_rise;
            else
                trig_hit = 1'b1;
        end
    end

    assign arm_ok    = arm && (cap_len != '0) &&
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign beat_load = !abort &&
                       (trig_hit || ((state_q == ST_CAPTURE) && (cnt_q != '0)));

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            mode_q   <= '0;
            tvalid_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= '0;
            sysref_q <= 1'b0;
            sysref_d <= 1'b0;
        end else begin
            sysref_q <= sysref;
            sysref_d <= sysref_q;
            ovf_q    <= ovf_q | (m_axis_tvalid & ~m_axis_tready);
            if (abort) begin
                state_q  <= ST_IDLE;
                tvalid_q <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (arm_ok) begin
                            len_q   <= cap_len;
                            sel_q   <= src_sel;
                            mode_q  <= trig_mode;
                            ovf_q   <= '0;
                            done_q  <= 1'b0;
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_hit) begin
                            state_q  <= ST_CAPTURE;
                            tvalid_q <= 1'b1;
                            cnt_q    <= len_q - LEN_W'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        if (cnt_q == '0) begin
                            state_q  <= ST_DONE;
                            tvalid_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - LEN_W'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef ADC_BUF_CAPTURE_TEST_PATTERN_EN
    always_ff @(posedge aclk or posedge arst) begin
        if (arst)
            tp_q <= 1'b0;
        else if (!abort && arm_ok)
            tp_q <= test_pattern_en;
    end
`else
    logic unused_tp;
    assign unused_tp = test_pattern_en;
    assign tp_q      = 1'b0;
`endif

    for (genvar b = 0; b < NBUF; b++) begin : g_buf
        adc_cap_chsel #(
            .NCH       (NCH),
            .ADC_WIDTH (ADC_WIDTH),
            .SEL_W     (SEL_W)
        ) u_chsel (
            .aclk   (aclk),
            .arst   (arst),
            .s_data (s_axis_tdata),
            .sel    (sel_q[b*SEL_W +: SEL_W]),
            .load   (beat_load),
            .first  (trig_hit),
            .tp_en  (tp_q),
            .m_data (m_axis_tdata[b*ADC_WIDTH +: ADC_WIDTH])
        );
    end

    assign s_axis_tready = '1;
    assign m_axis_tvalid = {NBUF{tvalid_q}};
    assign state         = state_q;
    assign done          = done_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_adc_buf_capture.sv
// Directed bench for adc_buf_capture with hand-derived expectations.
module tb_adc_buf_capture;

    logic         aclk = 1'b0;
    logic         arst;
    logic [511:0] s_axis_tdata;
    logic [3:0]   s_axis_tvalid;
    logic [3:0]   s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [3:0]   m_axis_tvalid;
    logic [3:0]   m_axis_tready;
    logic [7:0]   src_sel;
    logic [1:0]   trig_mode;
    logic [15:0]  cap_len;
    logic         arm, sw_trig, abort, sysref, test_pattern_en;
    logic [1:0]   state;
    logic         done;
    logic [3:0]   overflow;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    bit sysref_run = 1'b0;

    adc_buf_capture dut (
        .aclk            (aclk),
        .arst            (arst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .src_sel         (src_sel),
        .trig_mode       (trig_mode),
        .cap_len         (cap_len),
        .arm             (arm),
        .sw_trig         (sw_trig),
        .abort           (abort),
        .sysref          (sysref),
        .test_pattern_en (test_pattern_en),
        .state           (state),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 aclk = ~aclk;

    // Source beat for channel k in cycle c: lane i = {k, i, c[7:0]}.
    function automatic logic [127:0] beat(input int k, input int c);
        logic [127:0] v;
        for (int i = 0; i < 8; i++)
            v[i*16 +: 16] = {4'(k), 4'(i), 8'(c)};
        return v;
    endfunction

    function automatic logic [511:0] exp_vec(input int s0, input int s1,
                                             input int s2, input int s3, input int c);
        return {beat(s3, c), beat(s2, c), beat(s1, c), beat(s0, c)};
    endfunction

    function automatic logic [511:0] pat_vec(input int base);
        logic [511:0] v;
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                v[b*128 + i*16 +: 16] = 16'(base + i);
        return v;
    endfunction

    task automatic drive_src();
        for (int k = 0; k < 4; k++)
            s_axis_tdata[k*128 +: 128] = beat(k, cyc);
        if (sysref_run)
            sysref = (cyc % 16) < 8;
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        cyc++;
        drive_src();
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        int n;
        int arm_cyc;

        arst = 1'b1;
        s_axis_tvalid = 4'hF;
        m_axis_tready = 4'hF;
        src_sel = 8'hE4;
        trig_mode = 2'd0;
        cap_len = 16'd4;
        arm = 0; sw_trig = 0; abort = 0; sysref = 0; test_pattern_en = 0;
        drive_src();
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        arst = 1'b0;
        tick();
        chk("tready_ones", s_axis_tready, 4'hF);

        // arm with zero length is ignored
        cap_len = 16'd0;
        pulse_arm();
        chk("len0_state", state, 0);
        tick();
        chk("len0_state2", state, 0);

        // sw_trig coincident with arm in IDLE must not trigger
        cap_len = 16'd4;
        arm = 1'b1; sw_trig = 1'b1;
        tick();
        arm = 1'b0; sw_trig = 1'b0;
        chk("coinc_state", state, 1);
        tick();
        chk("coinc_state2", state, 1);
        chk("coinc_tvalid", m_axis_tvalid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("coinc_abort", state, 0);

        // software trigger, len 4, sw_trig 5 cycles after arm
        pulse_arm();
        chk("sw_armed", state, 1);
        tick(); tick(); tick(); tick();
        chk("sw_pre_tvalid", m_axis_tvalid, 0);
        sw_trig = 1'b1;
        tick();
        sw_trig = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("sw_state", state, 2);
            chk("sw_tvalid", m_axis_tvalid, 4'hF);
            chk("sw_data", m_axis_tdata, exp_vec(0, 1, 2, 3, cyc - 1));
            tick();
        end
        chk("sw_done_state", state, 3);
        chk("sw_done", done, 1);
        chk("sw_post_tvalid", m_axis_tvalid, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("done_abort_state", state, 0);
        chk("done_abort_done", done, 0);

        // sysref trigger, len 20 so a second edge lands mid-capture
        trig_mode = 2'd1;
        cap_len = 16'd20;
        sysref_run = 1'b1;
        n = 0;
        while ((cyc % 16) != 5 && n < 32) begin tick(); n++; end
        arm_cyc = cyc;
        pulse_arm();
        n = 0;
        while (m_axis_tvalid == 4'h0 && n < 40) begin tick(); n++; end
        chk("sysref_start", cyc, arm_cyc + 13);
        chk("sysref_data", m_axis_tdata, exp_vec(0, 1, 2, 3, cyc - 1));
        n = 0;
        while (m_axis_tvalid == 4'hF && n < 60) begin n++; tick(); end
        chk("sysref_beats", n, 20);
        chk("sysref_done_state", state, 3);
        sysref_run = 1'b0;
        sysref = 1'b0;

        // routing with immediate trigger; src_sel changes after arm must not matter
        trig_mode = 2'd2;
        cap_len = 16'd3;
        src_sel = {2'd2, 2'd3, 2'd0, 2'd0};
        pulse_arm();
        src_sel = 8'hE4;
        chk("route_armed", state, 1);
        tick();
        for (int j = 0; j < 3; j++) begin
            chk("route_tvalid", m_axis_tvalid, 4'hF);
            chk("route_data", m_axis_tdata, exp_vec(0, 0, 3, 2, cyc - 1));
            tick();
        end
        chk("route_done_state", state, 3);

        // back-pressure on buffer 1 for beats 2 and 3 of 8
        cap_len = 16'd8;
        pulse_arm();
        tick();
        for (int j = 0; j < 8; j++) begin
            chk("bp_tvalid", m_axis_tvalid, 4'hF);
            m_axis_tready = (j == 2 || j == 3) ? 4'b1101 : 4'hF;
            tick();
        end
        m_axis_tready = 4'hF;
        chk("bp_done_state", state, 3);
        chk("bp_done", done, 1);
        chk("bp_overflow", overflow, 4'b0010);

        // abort at beat 3 of a len-100 capture
        cap_len = 16'd100;
        pulse_arm();
        tick();
        chk("abort_ovf_cleared", overflow, 0);
        tick(); tick(); tick();
        chk("abort_beat3_tvalid", m_axis_tvalid, 4'hF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", state, 0);
        chk("abort_tvalid", m_axis_tvalid, 0);
        tick();
        chk("abort_tvalid2", m_axis_tvalid, 0);

        // asynchronous reset mid-capture
        cap_len = 16'd10;
        pulse_arm();
        tick(); tick();
        chk("arst_pre_tvalid", m_axis_tvalid, 4'hF);
        arst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_tdata", m_axis_tdata, 0);
        chk("arst_done", done, 0);
        tick();
        arst = 1'b0;
        tick(); tick();
        chk("arst_post_state", state, 0);
        chk("arst_post_tvalid", m_axis_tvalid, 0);

        // test pattern request (honoured only when the feature is built in)
        trig_mode = 2'd2;
        cap_len = 16'd2;
        test_pattern_en = 1'b1;
        pulse_arm();
        test_pattern_en = 1'b0;
        tick();
`ifdef ADC_BUF_CAPTURE_TEST_PATTERN_EN
        chk("tp_beat0", m_axis_tdata, pat_vec(0));
        tick();
        chk("tp_beat1", m_axis_tdata, pat_vec(8));
`else
        chk("tp_ignored0", m_axis_tdata, exp_vec(0, 1, 2, 3, cyc - 1));
        tick();
        chk("tp_ignored1", m_axis_tdata, exp_vec(0, 1, 2, 3, cyc - 1));
`endif
        tick();
        chk("tp_done_state", state, 3);

        // maximum length completes without counter wrap
        cap_len = 16'hFFFF;
        pulse_arm();
        tick();
        n = 0;
        while (m_axis_tvalid == 4'hF && n < 70000) begin n++; tick(); end
        chk("maxlen_beats", n, 65535);
        chk("maxlen_state", state, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/adc_buf_capture.md
ADC_BUF_CAPTURE -- requirements
Module: adc_buf_capture

Interface
REQ-001 SHALL have parameter NCH, default 4, the number of ADC input streams.
REQ-002 SHALL have parameter NBUF, default 4, the number of buffer output streams.
REQ-003 SHALL have parameter ADC_WIDTH, default 128, the beat width (eight 16-bit samples).
REQ-004 SHALL have parameter LEN_W, default 16, the capture-length counter width.
REQ-005 SHALL have port aclk, input, 1 bit, the sole clock; all logic is on its rising edge.
REQ-006 SHALL have port arst, input, 1 bit, the asynchronous active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, NCH*ADC_WIDTH bits, ADC beats; channel k occupies slice k.
REQ-008 SHALL have ports s_axis_tvalid (input, NCH bits) and s_axis_tready (output, NCH bits), per-channel handshake.
REQ-009 SHALL have port m_axis_tdata, output, NBUF*ADC_WIDTH bits, buffer beats.
REQ-010 SHALL have ports m_axis_tvalid (output, NBUF bits) and m_axis_tready (input, NBUF bits), per-buffer handshake.
REQ-011 SHALL have port src_sel, input, NBUF*$clog2(NCH) bits, the channel index feeding each buffer.
REQ-012 SHALL have port trig_mode, input, 2 bits: 0 software, 1 sysref, 2 immediate, 3 treated as 0.
REQ-013 SHALL have port cap_len, input, LEN_W bits, the number of beats per capture.
REQ-014 SHALL have ports arm, sw_trig, abort and sysref, all inputs, 1 bit; arm, sw_trig and abort are single-cycle pulses.
REQ-015 SHALL have port test_pattern_en, input, 1 bit.
REQ-016 SHALL have ports state (output, 2 bits), done (output, 1 bit) and overflow (output, NBUF bits, sticky).

Function
REQ-017 SHALL tie s_axis_tready to all ones, so ADC streams are never back-pressured.
REQ-018 SHALL implement FSM states IDLE=0, ARMED=1, CAPTURE=2 and DONE=3, with state reflecting the current state.
REQ-019 SHALL, on arm in IDLE or DONE with cap_len != 0, latch cap_len, src_sel and trig_mode, clear overflow and done, and enter ARMED.
REQ-020 SHALL ignore arm when cap_len == 0, and ignore arm while in ARMED or CAPTURE.
REQ-021 SHALL trigger from ARMED to CAPTURE on: sw_trig (mode 0 or 3); a sysref rising edge, where sysref is registered once and the edge is detected against its previous registered value (mode 1); or the first ARMED cycle (mode 2).
REQ-022 SHALL ignore triggers outside ARMED, including an sw_trig coincident with arm in IDLE.
REQ-023 SHALL, for a trigger sampled in cycle T, drive m_axis_tvalid high for all buffers from T+1 through T+len, where buffer b carries the input of latched channel src_sel[b] registered one cycle earlier.
REQ-024 SHALL enter DONE at T+len+1 and hold done high until the next accepted arm or an abort.
REQ-025 SHALL count beats every CAPTURE cycle regardless of m_axis_tready, never stalling.
REQ-026 SHALL set overflow[b] when m_axis_tvalid[b] is high and m_axis_tready[b] is low; the beat is dropped.
REQ-027 SHALL drive m_axis_tvalid low outside CAPTURE.
REQ-028 SHALL take a latched src_sel value >= NCH as channel 0.
REQ-029 SHALL, on abort in any state, enter IDLE next cycle and drop tvalid; abort overrides a simultaneous arm or trigger.
REQ-030 SHALL accept cap_len = 2^LEN_W-1 and complete it with no counter wrap.

Reset
REQ-031 SHALL, on arst, asynchronously force state to IDLE, m_axis_tvalid, m_axis_tdata, done, overflow and the sysref register to 0, and latched configuration to 0.
REQ-032 SHALL, on arst asserted mid-capture, abort the capture with no further valid beats after release.

Configuration
REQ-033 SHALL, with ADC_BUF_CAPTURE_TEST_PATTERN_EN defined and test_pattern_en high at arm, replace each buffer beat with lane i = base+i (16-bit, wrapping), where base starts at 0 at T+1 and increments by 8 per beat.
REQ-034 SHALL, without ADC_BUF_CAPTURE_TEST_PATTERN_EN, keep the test_pattern_en port present but ignored, with no pattern logic synthesised.

Structure
REQ-035 SHALL place the state enum, the trig_mode encodings and the lane width constant (16) in package adc_buf_capture_pkg.
REQ-036 SHALL use one sub-module, adc_cap_chsel, instantiated NBUF times, providing the channel mux, optional pattern generator and output register.

Verification
REQ-037 SHALL cover software trigger: mode 0, len 4, sw_trig 5 cycles after arm -> 4 valid beats matching source data delayed 1 cycle, then done=1 and state=3.
REQ-038 SHALL cover sysref trigger: mode 1, sysref rising every 16 cycles, arm then edge -> capture starts the cycle after the registered edge; a second edge mid-capture has no effect.
REQ-039 SHALL cover routing: src_sel = {0,0,3,2} -> buffers 0 and 1 both carry channel 0, buffer 2 carries channel 3, buffer 3 carries channel 2.
REQ-040 SHALL cover back-pressure: m_axis_tready[1] low for 2 beats of a len-8 capture -> overflow = 4'b0010, done after exactly 8 cycles.
REQ-041 SHALL cover abort and reset: abort at beat 3 of len 100 -> state 0 next cycle with tvalid low; arst pulsed mid-capture -> all outputs 0.
REQ-042 SHALL cover boundaries: arm with cap_len 0 -> stays IDLE; with the macro defined, mode 2 and len 2 -> beat 0 lanes 0..7, beat 1 lanes 8..15.
